// File: rtl/inst_cache.sv
// Direct-mapped, read-only instruction cache with 4-word lines.
// A hit returns the word combinationally in the same cycle. A miss stalls the
// core and refills the whole line in word order 0..3 through a read handshake.
// A flush invalidates every line and aborts any refill in progress.
module inst_cache #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_data_o,
    output logic        inst_valid_o,
    input  logic        flush_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_rd_o,
    input  logic [31:0] mem_data_i,
    input  logic        mem_valid_i
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t                  state_reg, state_next;
    logic [1:0]              cnt_reg, cnt_next;
    logic [31:4]             miss_addr_reg, miss_addr_next;
    logic [LINES-1:0]        valid_reg;

    // Tag and data storage; read asynchronously so a hit costs no cycle.
    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES*4];

    logic [INDEX_BITS-1:0]   lookup_idx;
    logic [TAG_W-1:0]        lookup_tag;
    logic [1:0]              lookup_off;
    logic [INDEX_BITS-1:0]   miss_idx;
    logic [TAG_W-1:0]        miss_tag;
    logic                    lookup_hit;
    logic                    start_miss;
    logic                    word_accept;
    logic                    line_done;
    logic                    unused_addr_bits;

    assign lookup_off       = inst_addr_i[3:2];
    assign lookup_idx       = inst_addr_i[3+INDEX_BITS:4];
    assign lookup_tag       = inst_addr_i[31:4+INDEX_BITS];
    assign miss_idx         = miss_addr_reg[3+INDEX_BITS:4];
    assign miss_tag         = miss_addr_reg[31:4+INDEX_BITS];
    // Byte offset within a word is irrelevant for word fetches.
    assign unused_addr_bits = ^inst_addr_i[1:0];

    assign lookup_hit  = valid_reg[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    // A flush cycle neither hits nor starts a miss; a memory beat during a flush is dropped.
    assign start_miss  = (state_reg == IDLE) && !flush_i && !lookup_hit;
    assign word_accept = (state_reg == REFILL) && !flush_i && mem_valid_i;
    assign line_done   = word_accept && (cnt_reg == 2'd3);

    // State, word counter and latched miss address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 2'd0;
            miss_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            miss_addr_reg <= miss_addr_next;
        end
    end

    // Next-state logic: IDLE looks up, REFILL walks the four words of the line.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        miss_addr_next = miss_addr_reg;
        case (state_reg)
            IDLE: begin
                if (start_miss) begin
                    state_next     = REFILL;
                    cnt_next       = 2'd0;
                    miss_addr_next = inst_addr_i[31:4];
                end
            end
            REFILL: begin
                if (flush_i) begin
                    state_next = IDLE;
                end else if (mem_valid_i) begin
                    if (cnt_reg == 2'd3) begin
                        state_next = IDLE;
                        cnt_next   = 2'd0;
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: core sees hits only in IDLE; memory sees requests only in REFILL.
    always_comb begin
        inst_valid_o = (state_reg == IDLE) && !flush_i && lookup_hit;
        inst_data_o  = data_mem[{lookup_idx, lookup_off}];
        mem_rd_o     = (state_reg == REFILL);
        mem_addr_o   = (state_reg == REFILL) ? {miss_addr_reg, cnt_reg, 2'b00} : 32'd0;
    end

    // Refill writes: each accepted word, then the tag with the last word.
    always_ff @(posedge clk) begin
        if (rst && word_accept) begin
            data_mem[{miss_idx, cnt_reg}] <= mem_data_i;
        end
        if (rst && line_done) begin
            tag_mem[miss_idx] <= miss_tag;
        end
    end

    // One valid bit per line: cleared on reset/flush and when its line starts a
    // refill (the old contents are being overwritten), set when the refill completes.
    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (!rst || flush_i) begin
                    valid_reg[gi] <= 1'b0;
                end else if (line_done && (miss_idx == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end else if (start_miss && (lookup_idx == INDEX_BITS'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: cold miss, hit, conflict, wait states,
// flush mid-refill, flush in IDLE, address change during refill, reset mid-refill.
// The memory returns each word's own address as its data.
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_addr_i = 32'h0;
    logic [31:0] inst_data_o;
    logic        inst_valid_o;
    logic        flush_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_rd_o;
    logic [31:0] mem_data_i;
    logic        mem_valid_i = 1'b0;

    int errors = 0;
    int checks = 0;

    inst_cache #(.INDEX_BITS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_addr_i  (inst_addr_i),
        .inst_data_o  (inst_data_o),
        .inst_valid_o (inst_valid_o),
        .flush_i      (flush_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rd_o     (mem_rd_o),
        .mem_data_i   (mem_data_i),
        .mem_valid_i  (mem_valid_i)
    );

    always #5 clk = ~clk;

    // Memory model: data word equals its byte address.
    assign mem_data_i = mem_addr_o;

    // Move to the next cycle; inputs are driven 2 time units after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        // Reset
        inst_addr_i = 32'h40;
        repeat (2) @(posedge clk);
        #2;
        settle();
        chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("rst_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);

        // Cold miss at cycle 0, zero-wait memory
        next_cycle();
        rst = 1'b1;
        mem_valid_i = 1'b1;
        settle();
        chk("cold_c0_valid", {31'd0, inst_valid_o}, 32'd0);
        chk("cold_c0_rd", {31'd0, mem_rd_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            settle();
            chk("cold_rd", {31'd0, mem_rd_o}, 32'd1);
            chk("cold_addr", mem_addr_o, 32'h40 + 32'(4 * k));
            chk("cold_stall", {31'd0, inst_valid_o}, 32'd0);
        end
        next_cycle();
        settle();
        chk("cold_c5_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("cold_c5_data", inst_data_o, 32'h40);
        chk("cold_c5_rd", {31'd0, mem_rd_o}, 32'd0);
        inst_addr_i = 32'h4C;
        settle();
        chk("hit_4c_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("hit_4c_data", inst_data_o, 32'h4C);

        // Conflict: 0x140 shares index 4 with 0x40
        next_cycle();
        inst_addr_i = 32'h140;
        settle();
        chk("conf_miss", {31'd0, inst_valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            settle();
            chk("conf_addr", mem_addr_o, 32'h140 + 32'(4 * k));
        end
        next_cycle();
        settle();
        chk("conf_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("conf_data", inst_data_o, 32'h140);
        inst_addr_i = 32'h40;
        settle();
        chk("conf_40_miss", {31'd0, inst_valid_o}, 32'd0);

        // Wait states: the refill of 0x40 sees mem_valid_i every 3rd cycle
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 3; k++) begin
                next_cycle();
                mem_valid_i = (k == 2);
                settle();
                chk("wait_addr", mem_addr_o, 32'h40 + 32'(4 * w));
                chk("wait_rd", {31'd0, mem_rd_o}, 32'd1);
                chk("wait_stall", {31'd0, inst_valid_o}, 32'd0);
            end
        end
        next_cycle();
        mem_valid_i = 1'b1;
        settle();
        chk("wait_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("wait_data", inst_data_o, 32'h40);
        inst_addr_i = 32'h48;
        settle();
        chk("wait_data_48", inst_data_o, 32'h48);

        // Flush during the 2nd word of a refill
        next_cycle();
        inst_addr_i = 32'h80;
        settle();
        chk("fl_miss", {31'd0, inst_valid_o}, 32'd0);
        next_cycle();
        settle();
        chk("fl_w0", mem_addr_o, 32'h80);
        next_cycle();
        flush_i = 1'b1;
        settle();
        chk("fl_w1", mem_addr_o, 32'h84);
        chk("fl_w1_rd", {31'd0, mem_rd_o}, 32'd1);
        next_cycle();
        flush_i = 1'b0;
        settle();
        chk("fl_rd_drop", {31'd0, mem_rd_o}, 32'd0);
        chk("fl_refetch_miss", {31'd0, inst_valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            settle();
            chk("fl_refill_addr", mem_addr_o, 32'h80 + 32'(4 * k));
        end
        next_cycle();
        settle();
        chk("fl_hit_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("fl_hit_data", inst_data_o, 32'h80);

        // Flush in IDLE: no hit that cycle, no miss started, line invalid afterwards
        flush_i = 1'b1;
        settle();
        chk("fli_valid", {31'd0, inst_valid_o}, 32'd0);
        next_cycle();
        flush_i = 1'b0;
        settle();
        chk("fli_no_miss", {31'd0, mem_rd_o}, 32'd0);
        chk("fli_invalid", {31'd0, inst_valid_o}, 32'd0);

        // Address change during refill of 0x80
        next_cycle();
        settle();
        chk("ac_w0", mem_addr_o, 32'h80);
        for (int k = 1; k < 4; k++) begin
            next_cycle();
            inst_addr_i = 32'h200;
            settle();
            chk("ac_keep_line", mem_addr_o, 32'h80 + 32'(4 * k));
        end
        next_cycle();
        settle();
        chk("ac_200_miss", {31'd0, inst_valid_o}, 32'd0);
        chk("ac_idle_rd", {31'd0, mem_rd_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            settle();
            chk("ac_200_addr", mem_addr_o, 32'h200 + 32'(4 * k));
        end
        next_cycle();
        settle();
        chk("ac_200_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("ac_200_data", inst_data_o, 32'h200);
        inst_addr_i = 32'h84;
        settle();
        chk("ac_80_valid", {31'd0, inst_valid_o}, 32'd1);
        chk("ac_80_data", inst_data_o, 32'h84);

        // Reset during a refill of 0x300
        inst_addr_i = 32'h300;
        settle();
        chk("rr_miss", {31'd0, inst_valid_o}, 32'd0);
        next_cycle();
        settle();
        chk("rr_w0", mem_addr_o, 32'h300);
        next_cycle();
        rst = 1'b0;
        settle();
        next_cycle();
        settle();
        chk("rr_rd", {31'd0, mem_rd_o}, 32'd0);
        chk("rr_addr", mem_addr_o, 32'd0);
        chk("rr_valid", {31'd0, inst_valid_o}, 32'd0);
        rst = 1'b1;
        inst_addr_i = 32'h200;
        settle();
        chk("rr_200_miss", {31'd0, inst_valid_o}, 32'd0);
        inst_addr_i = 32'h80;
        settle();
        chk("rr_80_miss", {31'd0, inst_valid_o}, 32'd0);
        inst_addr_i = 32'h40;
        settle();
        chk("rr_40_miss", {31'd0, inst_valid_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
